// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter for the shared L1-to-L2 line-transfer port (L1I refills vs L1D refills/write-backs).
// One transaction in flight at a time; the L2 response is returned through a one-cycle registered stage.
module l1_l2_arbiter #(
    parameter int unsigned TNUM2         = 18,
    parameter int unsigned INUM2         = 8,
    parameter int unsigned BIT_WIDTH_low = 512,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     read_L1I_L2,
    input  logic [TNUM2+INUM2-1:0]   addr_L1I,
    output logic                     ready_L2_L1I,
    output logic [BIT_WIDTH_low-1:0] read_data_L2_L1I,
    input  logic                     read_L1D_L2,
    input  logic                     write_L1D_L2,
    input  logic [TNUM2+INUM2-1:0]   addr_L1D,
    input  logic [TNUM2+INUM2-1:0]   write_addr_L1D,
    input  logic [BIT_WIDTH_low-1:0] write_data_L1D,
    output logic                     ready_L2_L1D,
    output logic [BIT_WIDTH_low-1:0] read_data_L2_L1D,
    output logic                     read_L1_L2,
    output logic                     write_L1_L2,
    output logic [TNUM2+INUM2-1:0]   addr_L1_L2,
    output logic [TNUM2+INUM2-1:0]   write_addr_L1_L2,
    output logic [BIT_WIDTH_low-1:0] write_data_L1_L2,
    input  logic                     ready_L2_L1,
    input  logic [BIT_WIDTH_low-1:0] read_data_L2_L1,
    output logic [1:0]               grant_o,
    output logic                     err_o
);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]     state_q;
    logic           last_d_q;  // 1 when L1D owned the previous transaction
    logic [WDW-1:0] wd_q;
    logic           req_i;
    logic           req_d;
    logic           pick_d;

    always_comb begin
        req_i  = read_L1I_L2;
        req_d  = read_L1D_L2 | write_L1D_L2;
        pick_d = req_d & (~req_i | ~last_d_q);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q          <= IDLE;
            last_d_q         <= 1'b0;
            wd_q             <= '0;
            err_o            <= 1'b0;
            grant_o          <= 2'b00;
            read_L1_L2       <= 1'b0;
            write_L1_L2      <= 1'b0;
            addr_L1_L2       <= '0;
            write_addr_L1_L2 <= '0;
            write_data_L1_L2 <= '0;
            ready_L2_L1I     <= 1'b0;
            ready_L2_L1D     <= 1'b0;
            read_data_L2_L1I <= '0;
            read_data_L2_L1D <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (pick_d) begin
                        state_q          <= GRANT_D;
                        grant_o          <= 2'b10;
                        read_L1_L2       <= read_L1D_L2;
                        write_L1_L2      <= write_L1D_L2;
                        addr_L1_L2       <= addr_L1D;
                        write_addr_L1_L2 <= write_addr_L1D;
                        write_data_L1_L2 <= write_data_L1D;
                    end else if (req_i) begin
                        state_q          <= GRANT_I;
                        grant_o          <= 2'b01;
                        read_L1_L2       <= 1'b1;
                        write_L1_L2      <= 1'b0;
                        addr_L1_L2       <= addr_L1I;
                        write_addr_L1_L2 <= '0;
                        write_data_L1_L2 <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (ready_L2_L1) begin
                        state_q     <= RESP;
                        grant_o     <= 2'b00;
                        read_L1_L2  <= 1'b0;
                        write_L1_L2 <= 1'b0;
                        last_d_q    <= (state_q == GRANT_D);
                        if (state_q == GRANT_D) begin
                            ready_L2_L1D     <= 1'b1;
                            read_data_L2_L1D <= read_data_L2_L1;
                        end else begin
                            ready_L2_L1I     <= 1'b1;
                            read_data_L2_L1I <= read_data_L2_L1;
                        end
                    end else if (wd_q != WDW'(TIMEOUT)) begin
                        // Saturates at TIMEOUT; the transaction keeps waiting after err_o sets.
                        wd_q <= wd_q + WDW'(1);
                        if (wd_q == WDW'(TIMEOUT - 1)) begin
                            err_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    ready_L2_L1I <= 1'b0;
                    ready_L2_L1D <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_l1_l2_arbiter;
    localparam int unsigned TIMEOUT = 1024;
    localparam int unsigned AW = 26;
    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          nrst;
    logic          read_L1I_L2;
    logic [AW-1:0] addr_L1I;
    logic          ready_L2_L1I;
    logic [DW-1:0] read_data_L2_L1I;
    logic          read_L1D_L2;
    logic          write_L1D_L2;
    logic [AW-1:0] addr_L1D;
    logic [AW-1:0] write_addr_L1D;
    logic [DW-1:0] write_data_L1D;
    logic          ready_L2_L1D;
    logic [DW-1:0] read_data_L2_L1D;
    logic          read_L1_L2;
    logic          write_L1_L2;
    logic [AW-1:0] addr_L1_L2;
    logic [AW-1:0] write_addr_L1_L2;
    logic [DW-1:0] write_data_L1_L2;
    logic          ready_L2_L1;
    logic [DW-1:0] read_data_L2_L1;
    logic [1:0]    grant_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    l1_l2_arbiter #(
        .TNUM2        (18),
        .INUM2        (8),
        .BIT_WIDTH_low(DW),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .read_L1I_L2     (read_L1I_L2),
        .addr_L1I        (addr_L1I),
        .ready_L2_L1I    (ready_L2_L1I),
        .read_data_L2_L1I(read_data_L2_L1I),
        .read_L1D_L2     (read_L1D_L2),
        .write_L1D_L2    (write_L1D_L2),
        .addr_L1D        (addr_L1D),
        .write_addr_L1D  (write_addr_L1D),
        .write_data_L1D  (write_data_L1D),
        .ready_L2_L1D    (ready_L2_L1D),
        .read_data_L2_L1D(read_data_L2_L1D),
        .read_L1_L2      (read_L1_L2),
        .write_L1_L2     (write_L1_L2),
        .addr_L1_L2      (addr_L1_L2),
        .write_addr_L1_L2(write_addr_L1_L2),
        .write_data_L1_L2(write_data_L1_L2),
        .ready_L2_L1     (ready_L2_L1),
        .read_data_L2_L1 (read_data_L2_L1),
        .grant_o         (grant_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: owner of the port (0 none, 1 L1I, 2 L1D), the latched transaction, and who is
    // being answered this cycle.
    int            m_owner;
    int            m_resp;
    int            m_last;
    int            m_cyc;
    logic          m_err;
    logic          m_read;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rd;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_owner <= 0;
            m_resp  <= 0;
            m_last  <= 1;
            m_cyc   <= 0;
            m_err   <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_rd    <= '0;
        end else if (m_resp != 0) begin
            m_resp <= 0;
        end else if (m_owner == 0) begin
            m_cyc <= 0;
            if ((read_L1D_L2 || write_L1D_L2) && (!read_L1I_L2 || m_last == 1)) begin
                m_owner <= 2;
                m_read  <= read_L1D_L2;
                m_write <= write_L1D_L2;
                m_addr  <= addr_L1D;
                m_waddr <= write_addr_L1D;
                m_wdata <= write_data_L1D;
            end else if (read_L1I_L2) begin
                m_owner <= 1;
                m_read  <= 1'b1;
                m_write <= 1'b0;
                m_addr  <= addr_L1I;
                m_waddr <= '0;
                m_wdata <= '0;
            end
        end else if (ready_L2_L1) begin
            m_resp  <= m_owner;
            m_last  <= m_owner;
            m_owner <= 0;
            m_rd    <= read_data_L2_L1;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 >= TIMEOUT) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("read_L1_L2", read_L1_L2, (m_owner != 0) && m_read);
        check("write_L1_L2", write_L1_L2, (m_owner != 0) && m_write);
        check("addr_L1_L2", addr_L1_L2, m_addr);
        check("write_addr_L1_L2", write_addr_L1_L2, m_waddr);
        check("write_data_L1_L2", write_data_L1_L2, m_wdata);
        check("grant_o", grant_o, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
        check("ready_L2_L1I", ready_L2_L1I, m_resp == 1);
        check("ready_L2_L1D", ready_L2_L1D, m_resp == 2);
        check("err_o", err_o, m_err);
        if (m_resp == 1) check("read_data_L2_L1I", read_data_L2_L1I, m_rd);
        if (m_resp == 2) check("read_data_L2_L1D", read_data_L2_L1D, m_rd);
    end

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Waits (bounded) until the L2 request lines rise; returns the grant seen then.
    task automatic wait_req(output logic [1:0] g);
        int n = 0;
        while (!(read_L1_L2 || write_L1_L2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("l2_request_seen", read_L1_L2 | write_L1_L2, 1'b1);
        g = grant_o;
    endtask

    // L2 answers after lat cycles; the served requester drops its lines on seeing ready.
    task automatic respond(input int lat, input logic [DW-1:0] d,
                           output logic ri, output logic rd, output logic [DW-1:0] dat);
        repeat (lat) @(negedge clk);
        ready_L2_L1     = 1'b1;
        read_data_L2_L1 = d;
        @(negedge clk);
        ready_L2_L1     = 1'b0;
        read_data_L2_L1 = '0;
        ri  = ready_L2_L1I;
        rd  = ready_L2_L1D;
        dat = ready_L2_L1I ? read_data_L2_L1I : read_data_L2_L1D;
        if (ready_L2_L1I) read_L1I_L2 = 1'b0;
        if (ready_L2_L1D) begin
            read_L1D_L2  = 1'b0;
            write_L1D_L2 = 1'b0;
        end
        @(negedge clk);
        check("ready_single_cycle", {ready_L2_L1I, ready_L2_L1D}, 2'b00);
    endtask

    logic [1:0]    g;
    logic          ri;
    logic          rd;
    logic [DW-1:0] dat;
    logic [1:0]    tie_order[4];

    initial begin
        tie_order[0] = 2'b10;
        tie_order[1] = 2'b01;
        tie_order[2] = 2'b10;
        tie_order[3] = 2'b01;
        nrst = 1'b0;
        read_L1I_L2 = 1'b0;  addr_L1I = '0;
        read_L1D_L2 = 1'b0;  write_L1D_L2 = 1'b0;
        addr_L1D = '0;  write_addr_L1D = '0;  write_data_L1D = '0;
        ready_L2_L1 = 1'b0;  read_data_L2_L1 = '0;
        #1;
        check("rst_grant", grant_o, 2'b00);
        check("rst_read", read_L1_L2, 1'b0);
        check("rst_rdata_i", read_data_L2_L1I, '0);
        check("rst_rdata_d", read_data_L2_L1D, '0);
        check("rst_err", err_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // L1I refill alone
        read_L1I_L2 = 1'b1;
        addr_L1I    = 26'h00000A5;
        wait_req(g);
        check("t1_grant", g, 2'b01);
        check("t1_addr", addr_L1_L2, 26'h00000A5);
        check("t1_write", write_L1_L2, 1'b0);
        respond(4, {16{32'hCAFE0001}}, ri, rd, dat);
        check("t1_ready_i", ri, 1'b1);
        check("t1_ready_d", rd, 1'b0);
        check("t1_data", dat, {16{32'hCAFE0001}});

        // Simultaneous requests after reset: D first, then strict alternation
        do_reset();
        read_L1I_L2 = 1'b1;
        read_L1D_L2 = 1'b1;
        addr_L1D    = 26'h0000456;
        for (int i = 0; i < 4; i++) begin
            wait_req(g);
            check("t2_order", g, tie_order[i]);
            respond(2, {16{32'h1000_0000 + 32'(i)}}, ri, rd, dat);
            check("t2_ready_side", {rd, ri}, tie_order[i]);
            if (g == 2'b10) read_L1D_L2 = 1'b1;
            else read_L1I_L2 = 1'b1;
        end
        read_L1I_L2 = 1'b0;
        read_L1D_L2 = 1'b0;
        @(negedge clk);
        check("t2_idle", grant_o, 2'b00);

        // Write-back plus refill from L1D
        read_L1D_L2    = 1'b1;
        write_L1D_L2   = 1'b1;
        addr_L1D       = 26'h0000456;
        write_addr_L1D = 26'h0000123;
        write_data_L1D = {64{8'hAA}};
        wait_req(g);
        check("t3_grant", g, 2'b10);
        check("t3_rw", {read_L1_L2, write_L1_L2}, 2'b11);
        check("t3_waddr", write_addr_L1_L2, 26'h0000123);
        check("t3_wdata", write_data_L1_L2, {64{8'hAA}});
        repeat (2) @(negedge clk);
        check("t3_addr_held", addr_L1_L2, 26'h0000456);
        respond(3, {16{32'hD00D_F00D}}, ri, rd, dat);
        check("t3_ready", {rd, ri}, 2'b10);

        // Write-only L1D request
        write_L1D_L2   = 1'b1;
        write_addr_L1D = 26'h000BEEF;
        write_data_L1D = {16{32'h5A5A_0F0F}};
        wait_req(g);
        check("t3w_rw", {read_L1_L2, write_L1_L2}, 2'b01);
        respond(1, {16{32'h0BAD_0BAD}}, ri, rd, dat);
        check("t3w_ready", {rd, ri}, 2'b10);

        // Requester drops and inputs change mid-grant
        read_L1I_L2 = 1'b1;
        addr_L1I    = 26'h0000111;
        wait_req(g);
        check("t4_grant", g, 2'b01);
        read_L1I_L2 = 1'b0;
        addr_L1I    = 26'h0000222;
        read_L1D_L2 = 1'b1;
        addr_L1D    = 26'h0000333;
        repeat (3) @(negedge clk);
        check("t4_addr_held", addr_L1_L2, 26'h0000111);
        check("t4_grant_held", grant_o, 2'b01);
        respond(1, {16{32'h4444_0001}}, ri, rd, dat);
        check("t4_ready_i", {rd, ri}, 2'b01);
        wait_req(g);
        check("t4_next_d", g, 2'b10);
        check("t4_next_addr", addr_L1_L2, 26'h0000333);
        respond(1, {16{32'h4444_0002}}, ri, rd, dat);

        // Watchdog
        do_reset();
        read_L1D_L2 = 1'b1;
        addr_L1D    = 26'h0000777;
        wait_req(g);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("t5_err_before", err_o, 1'b0);
        @(negedge clk);
        check("t5_err_at", err_o, 1'b1);
        repeat (5) @(negedge clk);
        respond(0, {16{32'h7777_7777}}, ri, rd, dat);
        check("t5_late_ready", {rd, ri}, 2'b10);
        check("t5_err_sticky", err_o, 1'b1);

        // Asynchronous reset during GRANT_D, pending L1I served afterwards
        do_reset();
        read_L1D_L2 = 1'b1;
        addr_L1D    = 26'h0000456;
        read_L1I_L2 = 1'b1;
        addr_L1I    = 26'h00000A5;
        wait_req(g);
        check("t6_grant_d", g, 2'b10);
        #2;
        nrst = 1'b0;
        #1;
        check("t6_rst_grant", grant_o, 2'b00);
        check("t6_rst_read", read_L1_L2, 1'b0);
        check("t6_rst_addr", addr_L1_L2, '0);
        check("t6_rst_ready", {ready_L2_L1I, ready_L2_L1D}, 2'b00);
        read_L1D_L2 = 1'b0;
        @(negedge clk);
        #2;
        nrst = 1'b1;
        wait_req(g);
        check("t6_grant_i", g, 2'b01);
        check("t6_addr_i", addr_L1_L2, 26'h00000A5);
        respond(2, {16{32'h6666_0001}}, ri, rd, dat);
        check("t6_ready_i", {rd, ri}, 2'b01);
        check("t6_data_i", dat, {16{32'h6666_0001}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end
endmodule
